// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions for the transmit path (and the
//                matching receive path). Provides the parity mode and
//                transmitter state encodings, and the frame length helper.
//  Contents    : parity_e    - parity mode of a frame
//                tx_state_e  - transmitter FSM states
//                frame_clks  - clocks occupied by one complete frame
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Start bit + payload + optional parity bit + stop bits, each one bit time.
    function automatic int unsigned frame_clks(
        input int unsigned clks_per_bit,
        input int unsigned data_bits,
        input int unsigned parity_mode,
        input int unsigned stop_bits
    );
        return clks_per_bit * (1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. The head entry is
//                presented on dout whenever empty is low, so a consumer can
//                look at it and pop it in the same cycle.
//  Ports       : clk    in  system clock
//                rst    in  asynchronous active-high reset (flushes the FIFO)
//                push   in  store din at the clock edge (ignored while full)
//                pop    in  discard the head at the clock edge (ignored while
//                           empty)
//                din    in  WIDTH-bit write data
//                dout   out WIDTH-bit head entry, valid while !empty
//                full   out registered, DEPTH entries held
//                empty  out registered, no entries held
//                level  out registered entry count, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned C_PTR_W = $clog2(DEPTH);
    localparam int unsigned C_LVL_W = C_PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_LVL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;

    logic               w_do_push;
    logic               w_do_pop;
    logic [C_LVL_W-1:0] w_level_nxt;

    // A push while full is dropped even when a pop happens in the same cycle.
    assign w_do_push = push && !r_full;
    assign w_do_pop  = pop  && !r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_do_push, w_do_pop})
            2'b10:   w_level_nxt = r_level + C_LVL_W'(1);
            2'b01:   w_level_nxt = r_level - C_LVL_W'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == C_LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Storage needs no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Parametrised UART transmitter with an internal TX FIFO.
//                Frames are start bit, DATA_BITS payload bits (LSB first),
//                optional even/odd parity bit and STOP_BITS stop bits, each
//                bit lasting exactly CLKS_PER_BIT clocks. Queued entries are
//                sent back to back without an idle gap.
//  Ports       : clk      in  system clock
//                rst      in  asynchronous active-high reset
//                wr_en    in  push wr_data into the FIFO this cycle
//                wr_data  in  DATA_BITS payload
//                full     out FIFO full; writes are dropped while high
//                level    out number of queued entries
//                busy     out frame in flight or entries queued
//                tx       out registered serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5200,
    parameter int unsigned DATA_BITS    = 8,
    parameter parity_e     PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned C_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned C_IDX_W = $clog2(DATA_BITS);
    localparam int unsigned C_LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_IDX_W-1:0] C_DATA_LAST = C_IDX_W'(DATA_BITS - 1);
    localparam logic [C_IDX_W-1:0] C_STOP_LAST = C_IDX_W'(STOP_BITS - 1);
    localparam bit                 C_HAS_PAR   = (PARITY != PAR_NONE);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    logic                  w_pop;
    logic [DATA_BITS-1:0]  w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [C_LVL_W-1:0]    w_fifo_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    // ------------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------------
    tx_state_e            r_state;
    tx_state_e            w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic [C_IDX_W-1:0]   r_idx;
    logic [C_IDX_W-1:0]   w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_busy;
    logic                 w_bit_end;
    logic                 w_par_calc;

    // Parity is captured with the payload at pop time so the shift register
    // can be consumed destructively during the DATA state.
    assign w_par_calc = (PARITY == PAR_ODD) ? ~^w_fifo_dout : ^w_fifo_dout;
    assign w_bit_end  = (r_cnt == C_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        // The bit-time counter runs in every active state and wraps at each
        // bit boundary, so every bit is exactly CLKS_PER_BIT clocks long.
        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + C_CNT_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_par_nxt   = w_par_calc;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                    if (r_idx == C_DATA_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = C_HAS_PAR ? ST_PARITY : ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + C_IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                w_tx_nxt = r_par;
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                w_tx_nxt = 1'b1;
                // The bit index counts stop bits here.
                if (w_bit_end) begin
                    if (r_idx == C_STOP_LAST) begin
                        w_idx_nxt = '0;
                        // Chain straight into the next start bit when more
                        // data is queued, leaving no idle gap on the line.
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_shift_nxt = w_fifo_dout;
                            w_par_nxt   = w_par_calc;
                            w_state_nxt = ST_START;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + C_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // tx and busy are registered from the current state, so both lag the
    // state register by one clock and stay aligned with each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (r_state != ST_IDLE) || (w_fifo_level != '0);
        end
    end

    assign tx    = r_tx;
    assign busy  = r_busy;
    assign full  = w_fifo_full;
    assign level = w_fifo_level;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. Four instances with
//                different frame formats share one clock and reset. A frame
//                level model (queue + offset into the current frame) predicts
//                tx, busy, level and full every cycle; literal bit tables and
//                a mid-bit sampling receiver pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    // Instance configurations: 0 = 8N1 depth 4, 1 = 8E1, 2 = 8O2, 3 = 5N1 slow
    localparam int P_CPB [4] = '{4, 4, 4, 5200};
    localparam int P_DB  [4] = '{8, 8, 8, 5};
    localparam int P_PAR [4] = '{0, 1, 2, 0};
    localparam int P_SB  [4] = '{1, 1, 2, 1};
    localparam int P_DEP [4] = '{4, 8, 8, 8};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr;
    logic [7:0] wd [4];
    logic [3:0] tx_v, busy_v, full_v;
    logic [2:0] lvl_a;
    logic [3:0] lvl_b, lvl_c, lvl_d;
    int         dut_lvl [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr[0]), .wr_data(wd[0]),
        .full(full_v[0]), .level(lvl_a), .busy(busy_v[0]), .tx(tx_v[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_EVEN),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr[1]), .wr_data(wd[1]),
        .full(full_v[1]), .level(lvl_b), .busy(busy_v[1]), .tx(tx_v[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(uart_pkg::PAR_ODD),
                   .STOP_BITS(2), .FIFO_DEPTH(8)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr[2]), .wr_data(wd[2]),
        .full(full_v[2]), .level(lvl_c), .busy(busy_v[2]), .tx(tx_v[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(5200), .DATA_BITS(5), .PARITY(uart_pkg::PAR_NONE),
                   .STOP_BITS(1), .FIFO_DEPTH(8)) u_d (
        .clk(clk), .rst(rst), .wr_en(wr[3]), .wr_data(wd[3][4:0]),
        .full(full_v[3]), .level(lvl_d), .busy(busy_v[3]), .tx(tx_v[3]));

    always_comb begin
        dut_lvl[0] = int'(lvl_a);
        dut_lvl[1] = int'(lvl_b);
        dut_lvl[2] = int'(lvl_c);
        dut_lvl[3] = int'(lvl_d);
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------------
    int qd [4][16];
    int qh [4], qn [4];
    int m_act [4], m_off [4], m_byte [4];
    int e_tx [4], e_busy [4], e_lvl [4], e_full [4];

    function automatic int frame_len(input int i);
        return P_CPB[i] * (1 + P_DB[i] + ((P_PAR[i] != 0) ? 1 : 0) + P_SB[i]);
    endfunction

    // Line level at a given clock offset into a frame carrying byte b.
    function automatic int bitval(input int i, input int b, input int off);
        int slot;
        int p;
        slot = off / P_CPB[i];
        if (slot == 0) return 0;
        if (slot <= P_DB[i]) return (b >> (slot - 1)) & 1;
        if (P_PAR[i] != 0 && slot == P_DB[i] + 1) begin
            p = $countones(b) & 1;
            return (P_PAR[i] == 1) ? p : 1 - p;
        end
        return 1;
    endfunction

    task automatic model_step();
        int fl, nb;
        bit pop, push;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_act[i] = 0; m_off[i] = 0; m_byte[i] = 0; qh[i] = 0; qn[i] = 0;
                e_tx[i] = 1; e_busy[i] = 0; e_lvl[i] = 0; e_full[i] = 0;
            end else begin
                fl = frame_len(i);
                nb = 0;
                // Outputs after this edge reflect the frame position before it.
                e_tx[i]   = (m_act[i] != 0) ? bitval(i, m_byte[i], m_off[i]) : 1;
                e_busy[i] = (m_act[i] != 0 || qn[i] != 0) ? 1 : 0;
                pop  = (qn[i] > 0) && (m_act[i] == 0 || m_off[i] == fl - 1);
                push = (wr[i] == 1'b1) && (qn[i] < P_DEP[i]);
                if (pop) begin
                    nb    = qd[i][qh[i]];
                    qh[i] = (qh[i] + 1) % 16;
                    qn[i] = qn[i] - 1;
                end
                if (push) begin
                    qd[i][(qh[i] + qn[i]) % 16] = int'(wd[i]) & ((1 << P_DB[i]) - 1);
                    qn[i] = qn[i] + 1;
                end
                if (m_act[i] != 0) begin
                    if (m_off[i] == fl - 1) begin
                        if (pop) begin m_off[i] = 0; m_byte[i] = nb; end
                        else m_act[i] = 0;
                    end else begin
                        m_off[i] = m_off[i] + 1;
                    end
                end else if (pop) begin
                    m_act[i] = 1; m_off[i] = 0; m_byte[i] = nb;
                end
                e_lvl[i]  = qn[i];
                e_full[i] = (qn[i] == P_DEP[i]) ? 1 : 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.tx", i),    int'(tx_v[i]),   e_tx[i]);
            chk($sformatf("u%0d.busy", i),  int'(busy_v[i]), e_busy[i]);
            chk($sformatf("u%0d.level", i), dut_lvl[i],      e_lvl[i]);
            chk($sformatf("u%0d.full", i),  int'(full_v[i]), e_full[i]);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    // Expected line per bit slot for 0x55 8N1, 0x07 8E1, 0x07 8O2.
    int lit [3][12] = '{
        '{0, 1,0,1,0,1,0,1,0, 1, 1, 1},
        '{0, 1,1,1,0,0,0,0,0, 1, 1, 1},
        '{0, 1,1,1,0,0,0,0,0, 0, 1, 1}
    };

    task automatic wait_idle(input int i, input int lim);
        int c;
        c = 0;
        @(posedge clk); #1;
        while (busy_v[i] !== 1'b0 && c < lim) begin
            @(posedge clk); #1;
            c++;
        end
        chk($sformatf("idle_u%0d", i), int'(busy_v[i]), 0);
    endtask

    task automatic literal_frames();
        int s;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (k == 1) chk($sformatf("lat_idle_u%0d", i), int'(tx_v[i]), 1);
                if (k == 2) chk($sformatf("lat_start_u%0d", i), int'(tx_v[i]), 0);
                if (k >= 2 && ((k - 2) % 4) == 1) begin
                    s = (k - 2) / 4;
                    if (s < 12) chk($sformatf("lit_u%0d_slot%0d", i, s), int'(tx_v[i]), lit[i][s]);
                end
            end
            if (k >= 42 && k <= 49) chk("stop2_high_u2", int'(tx_v[2]), 1);
            if (k == 41) chk("busy_end_u0", int'(busy_v[0]), 1);
            if (k == 42) chk("busy_low_u0", int'(busy_v[0]), 0);
            if (k == 45) chk("busy_end_u1", int'(busy_v[1]), 1);
            if (k == 46) chk("busy_low_u1", int'(busy_v[1]), 0);
            if (k == 49) chk("busy_end_u2", int'(busy_v[2]), 1);
            if (k == 50) chk("busy_low_u2", int'(busy_v[2]), 0);
        end
    endtask

    task automatic fifo_tests();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            wr[0] = 1'b1;
            wd[0] = 8'(8'h11 * (j + 1));
        end
        @(negedge clk);
        chk("t3_level_peak", dut_lvl[0], 4);
        chk("t3_full", int'(full_v[0]), 1);
        wd[0] = 8'h66;
        @(negedge clk);
        wr[0] = 1'b0;
        chk("t4_level_hold", dut_lvl[0], 4);
        chk("t4_full_hold", int'(full_v[0]), 1);
        wait_idle(0, 400);
    endtask

    task automatic random_phase();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                wr[i] = ($urandom_range(0, 11) == 0);
                wd[i] = 8'($urandom);
            end
        end
        @(negedge clk);
        wr = 4'b0000;
        for (int i = 0; i < 3; i++) wait_idle(i, 1000);
    endtask

    // Mid-bit sampling receiver for the 9600 baud instance.
    task automatic rx_d();
        int c;
        logic [4:0] d;
        c = 0;
        while (tx_v[3] !== 1'b0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rxd_start_seen", (c < 100) ? 1 : 0, 1);
        repeat (2600) @(posedge clk);
        #1;
        chk("rxd_start_mid", int'(tx_v[3]), 0);
        for (int j = 0; j < 5; j++) begin
            repeat (5200) @(posedge clk);
            #1;
            d[j] = tx_v[3];
        end
        repeat (5200) @(posedge clk);
        #1;
        chk("rxd_stop", int'(tx_v[3]), 1);
        chk("rxd_byte", int'(d), 'h1F);
    endtask

    task automatic reset_test();
        @(negedge clk);
        wr[0] = 1'b1;
        wd[0] = 8'h35;
        @(negedge clk);
        wr[0] = 1'b0;
        // Data bit 3 of this frame is on the line after edges +18..+21.
        repeat (19) @(posedge clk);
        #1;
        chk("t5_bit3_low", int'(tx_v[0]), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", int'(tx_v), 'hF);
        chk("t5_rst_busy", int'(busy_v), 0);
        chk("t5_rst_full", int'(full_v), 0);
        chk("t5_rst_level", dut_lvl[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr[0] = 1'b1;
        wd[0] = 8'hA5;
        @(negedge clk);
        wr[0] = 1'b0;
        wait_idle(0, 100);
    endtask

    initial begin
        rst = 1'b1;
        wr  = 4'b0000;
        for (int i = 0; i < 4; i++) wd[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", int'(tx_v), 'hF);
        chk("reset_busy", int'(busy_v), 0);
        chk("reset_full", int'(full_v), 0);
        chk("reset_level_a", dut_lvl[0], 0);
        rst = 1'b0;
        @(negedge clk);
        wr    = 4'b1111;
        wd[0] = 8'h55;
        wd[1] = 8'h07;
        wd[2] = 8'h07;
        wd[3] = 8'h1F;
        @(negedge clk);
        wr = 4'b0000;
        fork
            rx_d();
            begin
                literal_frames();
                fifo_tests();
                random_phase();
            end
        join
        reset_test();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
